// File: rtl/serial_subtractor_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_16bit
//  Description : Bit-serial 16-bit unsigned subtractor with borrow-in and
//                borrow-out. A single full-subtractor cell and a borrow flop
//                process one bit per clock, LSB first, under a
//                start/busy/done handshake (IDLE -> SHIFT x16 -> DONE).
//                d = (a - b - bin) mod 2^16, bout = (a < b + bin).
//                Optional feature macro: SUB_OVERFLOW_EN adds the ovf output,
//                the two's-complement overflow flag of the subtraction.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        bin,
    output logic [15:0] d,
    output logic        bout,
    output logic        busy,
    output logic        done
`ifdef SUB_OVERFLOW_EN
    ,
    output logic        ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_a;       // minuend, shifted right one bit per step
    logic [15:0] r_b;       // subtrahend, shifted right one bit per step
    logic [14:0] r_res;     // difference bits 0..14 collected from the MSB side
    logic        r_br;      // running borrow between bit positions
    logic [3:0]  r_cnt;     // index of the bit processed on the next edge

    // Full-subtractor cell operating on the current LSB of each operand
    logic w_a_i;
    logic w_b_i;
    logic w_x;
    logic w_diff;
    logic w_br_next;

    assign w_a_i     = r_a[0];
    assign w_b_i     = r_b[0];
    assign w_x       = w_a_i ^ w_b_i;
    assign w_diff    = w_x ^ r_br;
    assign w_br_next = (~w_a_i & w_b_i) | (~w_x & r_br);

    // Control FSM, serial datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= 16'd0;
            r_b     <= 16'd0;
            r_res   <= 15'd0;
            r_br    <= 1'b0;
            r_cnt   <= 4'd0;
            d       <= 16'd0;
            bout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_res   <= 15'd0;
                        r_cnt   <= 4'd0;
                        busy    <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a   <= {1'b0, r_a[15:1]};
                    r_b   <= {1'b0, r_b[15:1]};
                    r_br  <= w_br_next;
                    r_res <= {w_diff, r_res[14:1]};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        // Bit 15 completes the word: publish the result
                        d       <= {w_diff, r_res};
                        bout    <= w_br_next;
`ifdef SUB_OVERFLOW_EN
                        // Operand sign bits are the current LSBs here
                        ovf     <= (w_a_i != w_b_i) & (w_diff != w_a_i);
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately not sampled in this state
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor_16bit
//  Description : Self-checking bench for serial_subtractor_16bit. A
//                cycle-level reference model based on plain 17-bit
//                arithmetic predicts busy/done/d/bout(/ovf) every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor_16bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        busy;
    logic        done;
`ifdef SUB_OVERFLOW_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .d     (d),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_d(input logic [15:0] x, input logic [15:0] y, input logic bi);
        logic [16:0] r;
        r = {1'b0, x} - {1'b0, y} - {16'd0, bi};
        return r[15:0];
    endfunction

    function automatic logic ref_bout(input logic [15:0] x, input logic [15:0] y, input logic bi);
        return ({1'b0, x} < ({1'b0, y} + {16'd0, bi}));
    endfunction

    function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y, input logic bi);
        logic [15:0] r;
        r = ref_d(x, y, bi);
        return (x[15] != y[15]) && (r[15] != x[15]);
    endfunction

    // m_age: 0 = idle, 1..16 = cycles since acceptance (busy), 17 = done cycle
    int          m_age     = 0;
    int          m_accepts = 0;
    logic [15:0] m_a = '0, m_b = '0;
    logic        m_bin = 1'b0;
    logic [15:0] exp_d    = '0;
    logic        exp_bout = 1'b0;
    logic        exp_ovf  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age    <= 0;
            exp_d    <= '0;
            exp_bout <= 1'b0;
            exp_ovf  <= 1'b0;
        end else if (m_age == 0) begin
            if (start) begin
                m_a       <= a;
                m_b       <= b;
                m_bin     <= bin;
                m_age     <= 1;
                m_accepts <= m_accepts + 1;
            end
        end else if (m_age < 16) begin
            m_age <= m_age + 1;
        end else if (m_age == 16) begin
            exp_d    <= ref_d(m_a, m_b, m_bin);
            exp_bout <= ref_bout(m_a, m_b, m_bin);
            exp_ovf  <= ref_ovf(m_a, m_b, m_bin);
            m_age    <= 17;
        end else begin
            m_age <= 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    int dut_dones = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", {31'd0, busy}, {31'd0, (m_age >= 1 && m_age <= 16)});
            check("done", {31'd0, done}, {31'd0, (m_age == 17)});
            check("d", {16'd0, d}, {16'd0, exp_d});
            check("bout", {31'd0, bout}, {31'd0, exp_bout});
`ifdef SUB_OVERFLOW_EN
            check("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
`endif
            if (busy && done) begin
                checks++;
                errors++;
                $display("FAIL busy_done_overlap actual=1 required=0 at %0t", $time);
            end
            if (done) dut_dones++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] xa, input logic [15:0] xb,
                          input logic xbin, input logic [15:0] ed, input logic eb, input logic eo);
        @(negedge clk);
        a = xa; b = xb; bin = xbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; bin = 1'b1;   // post-capture changes must not matter
        wait_done(name);
        check({name, "_d"}, {16'd0, d}, {16'd0, ed});
        check({name, "_bout"}, {31'd0, bout}, {31'd0, eb});
`ifdef SUB_OVERFLOW_EN
        check({name, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
        if (eo) begin end
`endif
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base_acc;
        int base_done;
        int guard;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_d", {16'd0, d}, 32'd0);
        check("rst_bout", {31'd0, bout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        // Latency: busy right after the accepting edge, done after E16
        @(negedge clk);
        a = 16'h1234; b = 16'h0234; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("lat_busy_e0", {31'd0, busy}, 32'd1);
        repeat (15) @(negedge clk);
        check("lat_busy_e15", {31'd0, busy}, 32'd1);
        check("lat_done_e15", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("lat_done_e16", {31'd0, done}, 32'd1);
        check("lat_d", {16'd0, d}, 32'h1000);
        check("lat_bout", {31'd0, bout}, 32'd0);
        @(negedge clk);
        check("lat_done_e17", {31'd0, done}, 32'd0);

        run_op("wrap",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op("allone", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op("sovf",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_op("small",  16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Starts while busy and during DONE are ignored
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        a = 16'h0000; b = 16'h0000; start = 1'b1;   // sampled at E5
        @(negedge clk);
        start = 1'b0;
        wait_done("ign");
        check("ign_d", {16'd0, d}, 32'h00FE);
        a = 16'h0000; b = 16'h0000; start = 1'b1;   // sampled in DONE
        @(negedge clk);
        start = 1'b0;
        check("ign_busy_after_done", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("ign_still_idle", {31'd0, busy}, 32'd0);
        check("ign_d_hold", {16'd0, d}, 32'h00FE);

        // Asynchronous reset mid-operation
        @(negedge clk);
        a = 16'h1234; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_d", {16'd0, d}, 32'd0);
        check("arst_bout", {31'd0, bout}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
`ifdef SUB_OVERFLOW_EN
        check("arst_ovf", {31'd0, ovf}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 16'h0010, 16'h0008, 1'b0, 16'h0008, 1'b0, 1'b0);

        // Randomized back-to-back operations
        base_acc  = m_accepts;
        base_done = dut_dones;
        guard = 0;
        while (m_accepts < base_acc + 1000 && guard < 1000 * 18 + 200) begin
            @(negedge clk);
            a     = 16'($urandom);
            b     = 16'($urandom);
            bin   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                a = 16'($urandom_range(0, 3) * 16'h5555);
                b = 16'($urandom_range(0, 3) * 16'h5555);
            end
            start = 1'b1;
            guard++;
        end
        @(negedge clk);
        start = 1'b0;
        if (m_accepts < base_acc + 1000) begin
            checks++;
            errors++;
            $display("FAIL rand_timeout actual=%0d required=1000", m_accepts - base_acc);
        end
        repeat (25) @(negedge clk);
        check("rand_done_count", 32'(dut_dones - base_done), 32'(m_accepts - base_acc));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
